// File: rtl/mod_reduce.sv
// Sequential restoring modular reduction: out = in mod mod, one dividend bit per cycle.
// Fixed latency of IN_W CALC cycles regardless of operand values; mod = 0 flags div0.
module mod_reduce #(
  parameter int unsigned IN_W = 16,
  parameter int unsigned N_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] in,
  input  logic [N_W-1:0]  mod,
  output logic [N_W-1:0]  out,
  output logic            finish,
  output logic            busy,
  output logic            div0
);

  localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned R_W   = N_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IN_W-1:0]   r_d,     w_d_nxt;
  logic [N_W-1:0]    r_n,     w_n_nxt;
  logic [N_W-1:0]    r_rem,   w_rem_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [N_W-1:0]    r_out,   w_out_nxt;
  logic              r_finish, w_finish_nxt;
  logic              r_busy,   w_busy_nxt;
  logic              r_div0,   w_div0_nxt;

  logic [R_W-1:0]    w_shift;
  logic              w_ge;
  logic [N_W-1:0]    w_sub;
  logic [N_W-1:0]    w_rem_upd;
  logic              w_last;

  // Compare/subtract run at N_W+1 bits; the stored remainder is < N so N_W bits hold it.
  assign w_shift   = {r_rem, r_d[IN_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_n});
  assign w_sub     = N_W'(w_shift - {1'b0, r_n});
  assign w_rem_upd = w_ge ? w_sub : w_shift[N_W-1:0];
  assign w_last    = (r_cnt == CNT_W'(IN_W - 1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_d_nxt      = r_d;
    w_n_nxt      = r_n;
    w_rem_nxt    = r_rem;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_finish_nxt = 1'b0;
    w_busy_nxt   = r_busy;
    w_div0_nxt   = r_div0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_d_nxt     = in;
          w_n_nxt     = mod;
          w_rem_nxt   = '0;
          w_cnt_nxt   = '0;
          w_div0_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_rem_nxt = w_rem_upd;
        w_d_nxt   = r_d << 1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_state_nxt  = DONE;
          w_finish_nxt = 1'b1;
          if (r_n == '0) begin
            w_out_nxt  = '1;
            w_div0_nxt = 1'b1;
          end else begin
            w_out_nxt  = w_rem_upd;
          end
        end
      end
      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_d      <= '0;
      r_n      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_d      <= w_d_nxt;
      r_n      <= w_n_nxt;
      r_rem    <= w_rem_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_finish <= w_finish_nxt;
      r_busy   <= w_busy_nxt;
      r_div0   <= w_div0_nxt;
    end
  end

  assign out    = r_out;
  assign finish = r_finish;
  assign busy   = r_busy;
  assign div0   = r_div0;

endmodule

// File: tb/tb_mod_reduce.sv
// Directed bench for mod_reduce: latency, remainder values, div0, start masking, reset abort.
module tb_mod_reduce;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [7:0]  mod;
  logic [7:0]  out;
  logic        finish;
  logic        busy;
  logic        div0;

  int n_checks = 0;
  int n_pass   = 0;

  mod_reduce #(.IN_W(16), .N_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .mod(mod),
    .out(out), .finish(finish), .busy(busy), .div0(div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request, scrambles operands after acceptance, and profiles the following 24 cycles.
  task automatic run_op(input logic [15:0] a, input logic [7:0] m, input bit repulse,
                        output int lat, output int nfin, output int nbusy);
    lat = -1; nfin = 0; nbusy = 0;
    @(negedge clk);
    start = 1'b1; in = a; mod = m;
    @(posedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin start = 1'b0; in = 16'hA5A5; mod = 8'h3C; end
      if (repulse && (k == 5 || k == 16)) begin start = 1'b1; in = 16'd1000; mod = 8'd7; end
      if (repulse && (k == 6 || k == 17)) start = 1'b0;
      if (busy) nbusy++;
      if (finish) begin nfin++; if (lat < 0) lat = k; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in = '0; mod = '0;
    #1;
    n_checks++; if (out !== 8'd0) $display("FAIL reset_out: got %0h want 0", out); else n_pass++;
    n_checks++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", finish); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (div0 !== 1'b0) $display("FAIL reset_div0: got %b want 0", div0); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, nfin, nbusy;
    run_op(16'd684, 8'd13, 1'b0, lat, nfin, nbusy);
    n_checks++; if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (nfin !== 1) $display("FAIL basic_finish_count: got %0d want 1", nfin); else n_pass++;
    n_checks++; if (nbusy !== 17) $display("FAIL basic_busy_cycles: got %0d want 17", nbusy); else n_pass++;
    n_checks++; if (out !== 8'd8) $display("FAIL basic_out: got %0d want 8", out); else n_pass++;
    n_checks++; if (div0 !== 1'b0) $display("FAIL basic_div0: got %b want 0", div0); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [15:0] va [4] = '{16'd65535, 16'd65535, 16'd100, 16'd12345};
    logic [7:0]  vm [4] = '{8'd255,    8'd254,    8'd200,  8'd1};
    logic [7:0]  ve [4] = '{8'd0,      8'd3,      8'd100,  8'd0};
    int lat, nfin, nbusy;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vm[i], 1'b0, lat, nfin, nbusy);
      n_checks++;
      if (lat !== 16) $display("FAIL bound%0d_latency: got %0d want 16", i, lat); else n_pass++;
      n_checks++;
      if (nfin !== 1) $display("FAIL bound%0d_finish_count: got %0d want 1", i, nfin); else n_pass++;
      n_checks++;
      if (out !== ve[i]) $display("FAIL bound%0d_out: %0d mod %0d got %0d want %0d", i, va[i], vm[i], out, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div0();
    int lat, nfin, nbusy;
    run_op(16'd500, 8'd0, 1'b0, lat, nfin, nbusy);
    n_checks++; if (lat !== 16) $display("FAIL div0_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (nbusy !== 17) $display("FAIL div0_busy_cycles: got %0d want 17", nbusy); else n_pass++;
    n_checks++; if (out !== 8'hFF) $display("FAIL div0_out: got %0h want ff", out); else n_pass++;
    n_checks++; if (div0 !== 1'b1) $display("FAIL div0_flag: got %b want 1", div0); else n_pass++;
    run_op(16'd500, 8'd7, 1'b0, lat, nfin, nbusy);
    n_checks++; if (div0 !== 1'b0) $display("FAIL div0_cleared: got %b want 0", div0); else n_pass++;
    n_checks++; if (out !== 8'd3) $display("FAIL div0_next_out: got %0d want 3", out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, nfin, nbusy;
    run_op(16'd684, 8'd13, 1'b1, lat, nfin, nbusy);
    n_checks++; if (lat !== 16) $display("FAIL b2b_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (nfin !== 1) $display("FAIL b2b_finish_count: got %0d want 1", nfin); else n_pass++;
    n_checks++; if (nbusy !== 17) $display("FAIL b2b_busy_cycles: got %0d want 17", nbusy); else n_pass++;
    n_checks++; if (out !== 8'd8) $display("FAIL b2b_out: got %0d want 8", out); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (out !== 8'd8) $display("FAIL b2b_out_hold: got %0d want 8", out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, nfin, nbusy;
    int seen_fin = 0;
    run_op(16'd100, 8'd200, 1'b0, lat, nfin, nbusy);
    @(negedge clk);
    start = 1'b1; in = 16'd684; mod = 8'd13;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (finish) seen_fin++;
    end
    n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out !== 8'd0) $display("FAIL rmid_out: got %0d want 0", out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (finish !== 1'b0) $display("FAIL rmid_finish: got %b want 0", finish); else n_pass++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (finish) seen_fin++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (finish) seen_fin++;
    end
    n_checks++; if (seen_fin !== 0) $display("FAIL rmid_no_finish: got %0d pulses want 0", seen_fin); else n_pass++;
    run_op(16'd684, 8'd13, 1'b0, lat, nfin, nbusy);
    n_checks++; if (lat !== 16) $display("FAIL rmid_restart_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (out !== 8'd8) $display("FAIL rmid_restart_out: got %0d want 8", out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
